// File: rtl/mux_4x1.sv
// -----------------------------------------------------------------------------
// mux_4x1
//
// Four-way data selector. Built as a tree of three 2:1 muxes: two in the
// first stage switched by sel[0], one in the second stage switched by sel[1].
// The combinational result drives out. A registered copy drives out_q for
// downstream timing closure.
//
// An optional statistics block counts the clock edges on which sel differed
// from its previously sampled value. This block is compiled in only when the
// macro MUX_4X1_SEL_STATS_EN is defined. When the macro is absent,
// sel_changes is tied to zero.
//
// Parameters:
//   WIDTH        data width of p, q, r, s, out, out_q
//   CNT_W        width of the sel_changes counter
//
// Ports:
//   clk          rising-edge clock for the registered path
//   rst_n        asynchronous active-low reset (registered state only)
//   p, q, r, s   data inputs, selected by sel = 00, 01, 10, 11
//   sel          2-bit select
//   out          combinational selected data; independent of clk and rst_n
//   out_q        out registered on clk
//   sel_changes  saturating count of edges where sel != previous sampled sel
// -----------------------------------------------------------------------------
module mux_4x1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] s,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [CNT_W-1:0] sel_changes
);

    logic [WIDTH-1:0] m0;
    logic [WIDTH-1:0] m1;
    logic [WIDTH-1:0] out_q_reg;

    // Each bit uses a conditional operator. If a select bit is unknown, that
    // output bit resolves only when both candidate inputs agree.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign m0[gi]  = sel[0] ? q[gi]  : p[gi];
            assign m1[gi]  = sel[0] ? s[gi]  : r[gi];
            assign out[gi] = sel[1] ? m1[gi] : m0[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q_reg <= '0;
        end else begin
            out_q_reg <= out;
        end
    end

    assign out_q = out_q_reg;

`ifdef MUX_4X1_SEL_STATS_EN
    logic [1:0]       sel_prev_reg;
    logic [CNT_W-1:0] sel_changes_reg;
    logic [CNT_W-1:0] sel_changes_next;

    // Saturate at all-ones so that a long-running toggle never wraps the
    // count back to a small, misleading value.
    always_comb begin
        sel_changes_next = sel_changes_reg;
        if ((sel != sel_prev_reg) && (sel_changes_reg != {CNT_W{1'b1}})) begin
            sel_changes_next = sel_changes_reg + 1'b1;
        end
    end

    // sel_prev resets to 00. The first edge after reset release is therefore
    // counted whenever sel is not 00 at that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_prev_reg    <= 2'b00;
            sel_changes_reg <= '0;
        end else begin
            sel_prev_reg    <= sel;
            sel_changes_reg <= sel_changes_next;
        end
    end

    assign sel_changes = sel_changes_reg;
`else
    assign sel_changes = '0;
`endif

endmodule

// File: tb/tb_mux_4x1.sv
// -----------------------------------------------------------------------------
// tb_mux_4x1
//
// Checks mux_4x1 against a behavioural reference. The reference selects from
// an array indexed by sel. It models the register as the previous-edge
// selection, and the statistics block as a saturating edge count.
//
// The bench runs directed steps from the test plan first, then randomized
// traffic, then a saturation run. It prints one line per transaction and one
// summary line at the end.
// -----------------------------------------------------------------------------
module tb_mux_4x1;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] p, q, r, s;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic [CNT_W-1:0] sel_changes;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [WIDTH-1:0] exp_q;
    logic [1:0]       prev_sel;
    int               chg_cnt;

    mux_4x1 #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .p          (p),
        .q          (q),
        .r          (r),
        .s          (s),
        .sel        (sel),
        .out        (out),
        .out_q      (out_q),
        .sel_changes(sel_changes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The reference picks from an array. It does not use a tree of 2:1 muxes.
    function automatic logic [WIDTH-1:0] ref_out();
        logic [WIDTH-1:0] src [4];
        src = '{p, q, r, s};
        return src[sel];
    endfunction

    function automatic logic [CNT_W-1:0] ref_changes();
`ifdef MUX_4X1_SEL_STATS_EN
        return chg_cnt[CNT_W-1:0];
`else
        return '0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q    = '0;
        prev_sel = 2'b00;
        chg_cnt  = 0;
    endtask

    // Advance one rising edge. The model samples the same stable inputs as
    // the DUT. Outputs are then compared 1 time unit after the edge.
    task automatic step(input string tag);
        logic [WIDTH-1:0] sampled;
        sampled = ref_out();
        @(posedge clk);
        if (rst_n) begin
            if (sel != prev_sel) chg_cnt = (chg_cnt < SAT) ? chg_cnt + 1 : SAT;
            prev_sel = sel;
            exp_q    = sampled;
        end
        #1;
        chk({tag, ".out_q"}, 32'(out_q), 32'(exp_q));
        chk({tag, ".sel_changes"}, 32'(sel_changes), 32'(ref_changes()));
        $display("[%0t] %s sel=%b p=%h q=%h r=%h s=%h out=%h out_q=%h sel_changes=%0d",
                 $time, tag, sel, p, q, r, s, out, out_q, sel_changes);
    endtask

    task automatic chk_out(input string tag);
        #1;
        chk({tag, ".out"}, 32'(out), 32'(ref_out()));
    endtask

    initial begin
        rst_n = 1'b0;
        p = '0; q = '0; r = '0; s = '0; sel = 2'b00;
        model_reset();

        // Reset state. out must be valid even while reset is held.
        #2;
        chk_out("reset");
        chk("reset.out_zero", 32'(out), 32'h0);
        chk("reset.out_q", 32'(out_q), 32'h0);
        chk("reset.sel_changes", 32'(sel_changes), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("zero");

        // With sel = 01, q is selected. out updates at once; out_q one edge later.
        p = 8'h01; q = 8'h01; r = 8'h00; s = 8'h00; sel = 2'b01;
        chk_out("sel01");
        chk("sel01.out_one", 32'(out), 32'h1);
        step("sel01");
        chk("sel01.out_q_one", 32'(out_q), 32'h1);

        // With sel = 00, p is selected and r is ignored.
        p = 8'h00; q = 8'h00; sel = 2'b00;
        chk_out("p0");
        p = 8'h01; r = 8'h01;
        chk_out("p1");
        chk("p1.out_one", 32'(out), 32'h1);
        step("p1");

        // Walk all select values.
        p = 8'h01; q = 8'h00; r = 8'h01; s = 8'h00;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            chk_out($sformatf("walk%0d", i));
            step($sformatf("walk%0d", i));
        end

        // Assert reset asynchronously between edges while out_q = 1.
        sel = 2'b00;
        step("pre_rst");
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst.out_q", 32'(out_q), 32'h0);
        chk("async_rst.sel_changes", 32'(sel_changes), 32'h0);
        p = 8'hA5;
        chk_out("async_rst.track");
        step("in_rst");
        @(negedge clk);
        rst_n = 1'b1;
        sel = 2'b10;
        step("rst_release");

        // Randomized traffic. Data and select change together.
        for (int i = 0; i < 200; i++) begin
            p   = WIDTH'($urandom);
            q   = WIDTH'($urandom);
            r   = WIDTH'($urandom);
            s   = WIDTH'($urandom);
            sel = 2'($urandom_range(0, 3));
            chk_out($sformatf("rand%0d", i));
            step($sformatf("rand%0d", i));
        end

        // Saturation: clear, then toggle sel for 300 edges.
        #3;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sel = (i % 2 == 0) ? 2'b01 : 2'b10;
            step($sformatf("sat%0d", i));
        end
`ifdef MUX_4X1_SEL_STATS_EN
        chk("sat.final", 32'(sel_changes), 32'(SAT));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog: guarantees termination even if a wait never completes.
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
